neander_control: RTL and testbench

NEANDER_CONTROL -- requirements
Module: neander_control

---
 rtl/neander_control.sv | 160 ++++++++++++++++
 tb/tb_neander_control.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neander_control.sv
// rtl/neander_control.sv - Neander control unit: registers, instruction FSM and memory handshake.
// Define NEANDER_STEP_EN to add i_STEP and a STEP_WAIT state that gates every instruction fetch.
module neander_control (
  input  logic       i_CLK,
  input  logic       i_RST,
`ifdef NEANDER_STEP_EN
  input  logic       i_STEP,
`endif
  output logic [7:0] o_MEM_ADDR,
  output logic       o_MEM_RD,
  output logic       o_MEM_WR,
  output logic [7:0] o_MEM_WDATA,
  input  logic [7:0] i_MEM_RDATA,
  input  logic       i_MEM_ACK,
  output logic [7:0] o_ULA_A,
  output logic [7:0] o_ULA_B,
  output logic [2:0] o_ULA_SEL,
  input  logic [7:0] i_ULA_OUT,
  input  logic       i_ULA_ZERO,
  input  logic       i_ULA_NEG,
  output logic [7:0] o_AC,
  output logic [7:0] o_PC,
  output logic       o_N,
  output logic       o_Z,
  output logic       o_HALTED
);

  localparam logic [3:0] OP_STA = 4'h1, OP_LDA = 4'h2, OP_ADD = 4'h3, OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5, OP_NOT = 4'h6, OP_JMP = 4'h8, OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA, OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_OPER, S_READ, S_WRITE, S_EXEC, S_HALT
`ifdef NEANDER_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

  // Every path back to instruction fetch goes through this state.
`ifdef NEANDER_STEP_EN
  localparam state_t S_NEXT = S_STEP_WAIT;
`else
  localparam state_t S_NEXT = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d, ir_q, ir_d, ar_q, ar_d, dr_q, dr_d, ac_q, ac_d;
  logic       n_q, n_d, z_q, z_d;
  logic       rd_q, wr_q, halted_q;
  logic [7:0] addr_q;
  logic [3:0] opcode, rd_op;
  logic       ack_rd, ack_wr;
  logic       unused_ir_lo;

  assign opcode       = ir_q[7:4];
  assign rd_op        = i_MEM_RDATA[7:4];
  assign ack_rd       = i_MEM_ACK && rd_q;
  assign ack_wr       = i_MEM_ACK && wr_q;
  assign unused_ir_lo = ^ir_q[3:0];

  function automatic logic has_operand(input logic [3:0] op);
    case (op)
      OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP, OP_JN, OP_JZ: has_operand = 1'b1;
      default: has_operand = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ar_d    = ar_q;
    dr_d    = dr_q;
    ac_d    = ac_q;
    n_d     = n_q;
    z_d     = z_q;
    case (state_q)
      S_FETCH: if (ack_rd) begin
        ir_d = i_MEM_RDATA;
        pc_d = pc_q + 8'd1;
        if (rd_op == OP_HLT)          state_d = S_HALT;
        else if (has_operand(rd_op))  state_d = S_OPER;
        else                          state_d = S_EXEC;
      end
      S_OPER: if (ack_rd) begin
        case (opcode)
          OP_STA: begin ar_d = i_MEM_RDATA; pc_d = pc_q + 8'd1; state_d = S_WRITE; end
          OP_JMP: begin pc_d = i_MEM_RDATA; state_d = S_NEXT; end
          OP_JN:  begin pc_d = n_q ? i_MEM_RDATA : pc_q + 8'd1; state_d = S_NEXT; end
          OP_JZ:  begin pc_d = z_q ? i_MEM_RDATA : pc_q + 8'd1; state_d = S_NEXT; end
          default: begin ar_d = i_MEM_RDATA; pc_d = pc_q + 8'd1; state_d = S_READ; end
        endcase
      end
      S_READ: if (ack_rd) begin
        dr_d    = i_MEM_RDATA;
        state_d = S_EXEC;
      end
      S_WRITE: if (ack_wr) state_d = S_NEXT;
      S_EXEC: begin
        if (opcode inside {OP_LDA, OP_ADD, OP_OR, OP_AND, OP_NOT}) begin
          ac_d = i_ULA_OUT;
          n_d  = i_ULA_NEG;
          z_d  = i_ULA_ZERO;
        end
        state_d = S_NEXT;
      end
      S_HALT: state_d = S_HALT;
`ifdef NEANDER_STEP_EN
      S_STEP_WAIT: if (i_STEP) state_d = S_FETCH;
`endif
      default: state_d = S_NEXT;
    endcase
  end

  // Request strobes and address are registered from the next state, so they stay
  // stable for the whole wait and drop cleanly in the cycle after reset.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= S_NEXT;
      pc_q     <= 8'h00;
      ir_q     <= 8'h00;
      ar_q     <= 8'h00;
      dr_q     <= 8'h00;
      ac_q     <= 8'h00;
      n_q      <= 1'b0;
      z_q      <= 1'b1;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ar_q     <= ar_d;
      dr_q     <= dr_d;
      ac_q     <= ac_d;
      n_q      <= n_d;
      z_q      <= z_d;
      rd_q     <= (state_d == S_FETCH) || (state_d == S_OPER) || (state_d == S_READ);
      wr_q     <= (state_d == S_WRITE);
      addr_q   <= ((state_d == S_READ) || (state_d == S_WRITE)) ? ar_d : pc_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  assign o_MEM_ADDR  = addr_q;
  assign o_MEM_RD    = rd_q;
  assign o_MEM_WR    = wr_q;
  assign o_MEM_WDATA = ac_q;
  assign o_ULA_A     = ac_q;
  assign o_ULA_B     = (opcode == OP_NOT) ? ac_q : dr_q;
  assign o_ULA_SEL   = ir_q[6:4];
  assign o_AC        = ac_q;
  assign o_PC        = pc_q;
  assign o_N         = n_q;
  assign o_Z         = z_q;
  assign o_HALTED    = halted_q;

endmodule

// File: tb/tb_neander_control.sv
// tb/tb_neander_control.sv - Scoreboard bench: directed and random programs checked against an ISA-level model.
module tb_neander_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, ula_a, ula_b, ula_out, ac, pc;
  logic       mem_rd, mem_wr, mem_ack, ula_zero, ula_neg, n_flag, z_flag, halted;
  logic [2:0] ula_sel;
`ifdef NEANDER_STEP_EN
  logic step = 1'b1;
  localparam int STEP_EXTRA = 1;
`else
  localparam int STEP_EXTRA = 0;
`endif

  always #5 clk = ~clk;

  neander_control dut (
    .i_CLK(clk), .i_RST(rst),
`ifdef NEANDER_STEP_EN
    .i_STEP(step),
`endif
    .o_MEM_ADDR(mem_addr), .o_MEM_RD(mem_rd), .o_MEM_WR(mem_wr), .o_MEM_WDATA(mem_wdata),
    .i_MEM_RDATA(mem_rdata), .i_MEM_ACK(mem_ack),
    .o_ULA_A(ula_a), .o_ULA_B(ula_b), .o_ULA_SEL(ula_sel),
    .i_ULA_OUT(ula_out), .i_ULA_ZERO(ula_zero), .i_ULA_NEG(ula_neg),
    .o_AC(ac), .o_PC(pc), .o_N(n_flag), .o_Z(z_flag), .o_HALTED(halted)
  );

  // Environment: memory with random/fixed ACK delay, spurious idle ACKs, and the ALU.
  logic [7:0] mem  [256];
  logic [7:0] prog [256];
  logic load_req = 1'b0;
  int   fixed_delay = -1;
  bit   spur_en = 1'b0;
  bit   spur = 1'b0;
  int   wait_cnt = 0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = ((mem_rd || mem_wr) && wait_cnt == 0) || (!mem_rd && !mem_wr && spur);
  always_comb begin
    case (ula_sel)
      3'd2:    ula_out = ula_b;
      3'd3:    ula_out = ula_a + ula_b;
      3'd4:    ula_out = ula_a | ula_b;
      3'd5:    ula_out = ula_a & ula_b;
      3'd6:    ula_out = ~ula_a;
      default: ula_out = ula_b;
    endcase
  end
  assign ula_zero = (ula_out == 8'h00);
  assign ula_neg  = ula_out[7];

  always @(posedge clk) begin
    if (load_req) mem <= prog;
    else if (!rst && mem_wr && mem_ack) mem[mem_addr] <= mem_wdata;
    if (rst || !(mem_rd || mem_wr) || mem_ack)
      wait_cnt <= (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
    else if (wait_cnt > 0)
      wait_cnt <= wait_cnt - 1;
    spur <= spur_en && ($urandom_range(0, 2) == 0);
  end

  typedef struct {
    bit         fetch;
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ac;
    bit         n;
    bit         z;
    int         lat;
  } txn_t;
  txn_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic push(input bit fetch, input bit is_wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [7:0] acc, input bit n, input bit z, input int lat);
    txn_t t;
    t.fetch = fetch; t.is_wr = is_wr; t.addr = addr; t.wdata = wdata;
    t.ac = acc; t.n = n; t.z = z; t.lat = lat;
    exp_q.push_back(t);
  endtask

  // Instruction-set interpreter: emits the bus transactions each instruction must make,
  // tagging every fetch with the architectural state expected at that point.
  task automatic run_model(input int max_instr, output bit halt, output logic [7:0] pc_end);
    logic [7:0] m [256];
    logic [7:0] p, a, ir, opr, d;
    bit n, z;
    int lat;
    m = prog; p = 8'h00; a = 8'h00; n = 1'b0; z = 1'b1; lat = 0; halt = 1'b0;
    for (int k = 0; k < max_instr && !halt; k++) begin
      push(1'b1, 1'b0, p, 8'h00, a, n, z, lat);
      ir = m[p]; p = p + 8'd1; lat = 2;
      case (ir[7:4])
        4'hF: halt = 1'b1;
        4'h1: begin
          push(1'b0, 1'b0, p, 8'h00, a, n, z, 0);
          opr = m[p]; p = p + 8'd1;
          push(1'b0, 1'b1, opr, a, a, n, z, 0);
          m[opr] = a; lat = 3;
        end
        4'h2, 4'h3, 4'h4, 4'h5: begin
          push(1'b0, 1'b0, p, 8'h00, a, n, z, 0);
          opr = m[p]; p = p + 8'd1;
          push(1'b0, 1'b0, opr, 8'h00, a, n, z, 0);
          d = m[opr];
          case (ir[7:4])
            4'h2:    a = d;
            4'h3:    a = a + d;
            4'h4:    a = a | d;
            default: a = a & d;
          endcase
          n = a[7]; z = (a == 8'h00); lat = 4;
        end
        4'h6: begin a = ~a; n = a[7]; z = (a == 8'h00); end
        4'h8: begin push(1'b0, 1'b0, p, 8'h00, a, n, z, 0); p = m[p]; end
        4'h9: begin push(1'b0, 1'b0, p, 8'h00, a, n, z, 0); p = n ? m[p] : p + 8'd1; end
        4'hA: begin push(1'b0, 1'b0, p, 8'h00, a, n, z, 0); p = z ? m[p] : p + 8'd1; end
        default: ;
      endcase
    end
    pc_end = p;
  endtask

  // Monitor: pops one expectation per acknowledged request.
  int cyc = 0;
  int last_fetch_cyc = -1;
  bit unstable = 1'b0;
  bit prev_pend = 1'b0;
  logic [7:0] prev_addr = 8'h00, prev_wdata = 8'h00;
  logic prev_wr = 1'b0;
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        unstable = 1'b0; prev_pend = 1'b0; last_fetch_cyc = -1;
      end else begin
        if (prev_pend && (mem_rd || mem_wr) &&
            (mem_addr != prev_addr || mem_wdata != prev_wdata || mem_wr != prev_wr)) unstable = 1'b1;
        if (mem_rd && mem_wr) unstable = 1'b1;
        if (mem_ack && (mem_rd || mem_wr)) begin
          if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            check(mem_wr == t.is_wr && mem_addr == t.addr, "txn_kind_addr",
                  32'({mem_wr, mem_addr}), 32'({t.is_wr, t.addr}));
            if (t.is_wr) check(mem_wdata == t.wdata, "write_data", 32'(mem_wdata), 32'(t.wdata));
            check(!unstable, "req_stable_exclusive", 32'(unstable), 32'd0);
            if (t.fetch) begin
              check(ac == t.ac && n_flag == t.n && z_flag == t.z && pc == t.addr, "arch_state",
                    32'({ac, n_flag, z_flag, pc}), 32'({t.ac, t.n, t.z, t.addr}));
              if (fixed_delay == 0 && last_fetch_cyc >= 0 && t.lat > 0)
                check(cyc - last_fetch_cyc == t.lat + STEP_EXTRA, "latency",
                      32'(cyc - last_fetch_cyc), 32'(t.lat + STEP_EXTRA));
              last_fetch_cyc = cyc;
            end
          end
          unstable = 1'b0; prev_pend = 1'b0;
        end else begin
          prev_pend = mem_rd || mem_wr;
        end
        prev_addr = mem_addr; prev_wdata = mem_wdata; prev_wr = mem_wr;
      end
    end
  end

  task automatic check_reset_state(input string name);
    check(!mem_rd && !mem_wr && !halted && pc == 8'h00 && ac == 8'h00 && !n_flag && z_flag, name,
          32'({mem_rd, mem_wr, halted, pc, ac, n_flag, z_flag}), 32'({3'b000, 8'h00, 8'h00, 2'b01}));
  endtask

  task automatic run_prog(input int delay, input bit mid_read_reset);
    bit h;
    logic [7:0] pc_exp;
    int budget, busy;
    rst = 1'b1; fixed_delay = delay;
    load_req = 1'b1; @(posedge clk); #1 load_req = 1'b0;
    exp_q.delete();
    run_model(60, h, pc_exp);
    @(posedge clk); #1 rst = 1'b0;
    budget = 5000;
    if (mid_read_reset) begin
      while (!(mem_rd && mem_addr == 8'h80 && pc == 8'h02) && budget > 0) begin @(negedge clk); budget--; end
      check(budget > 0, "reach_data_read", 32'(budget), 32'd1);
      rst = 1'b1;
    end else begin
      while (exp_q.size() > 0 && budget > 0) begin @(negedge clk); budget--; end
      check(budget > 0, "drain_timeout", 32'(exp_q.size()), 32'd0);
      if (h) begin
        repeat (2) @(negedge clk);
        check(halted && pc == pc_exp, "halt_state", 32'({halted, pc}), 32'({1'b1, pc_exp}));
        busy = 0;
        repeat (10) begin @(negedge clk); if (mem_rd || mem_wr) busy++; end
        check(busy == 0, "halt_quiet", 32'(busy), 32'd0);
      end else begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      rst = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    check_reset_state("reset_after_prog");
    exp_q.delete();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  task automatic gen_random();
    int a;
    logic [3:0] op;
    a = 0;
    for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
    while (a < 'h60) begin
      op = 4'($urandom_range(0, 15));
      prog[a] = {op, 4'($urandom)}; a++;
      if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5}) begin prog[a] = 8'($urandom_range(8'h80, 8'hFF)); a++; end
      else if (op inside {4'h8, 4'h9, 4'hA}) begin prog[a] = 8'($urandom_range(0, 8'h5F)); a++; end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset_initial");

    clear_prog(); prog[0] = 8'h20; prog[1] = 8'h80; prog[2] = 8'hF0; prog[8'h80] = 8'h05;
    run_prog(0, 1'b0);
    clear_prog(); prog[0] = 8'h20; prog[1] = 8'h80; prog[2] = 8'h30; prog[3] = 8'h81; prog[4] = 8'hF0;
    prog[8'h80] = 8'hFF; prog[8'h81] = 8'h01;
    run_prog(0, 1'b0);
    clear_prog(); prog[0] = 8'h20; prog[1] = 8'h80; prog[2] = 8'h10; prog[3] = 8'h90;
    prog[4] = 8'h20; prog[5] = 8'h90; prog[6] = 8'hF0; prog[8'h80] = 8'h5A;
    run_prog(3, 1'b0);
    clear_prog(); prog[0] = 8'h20; prog[1] = 8'h80; prog[2] = 8'h90; prog[3] = 8'h40;
    prog[8'h40] = 8'h20; prog[8'h41] = 8'h81; prog[8'h42] = 8'h90; prog[8'h43] = 8'h10;
    prog[8'h44] = 8'hF0; prog[8'h10] = 8'hF0; prog[8'h80] = 8'h80; prog[8'h81] = 8'h01;
    run_prog(0, 1'b0);
    clear_prog(); prog[0] = 8'hA0; prog[1] = 8'h30; prog[2] = 8'hF0; prog[8'h30] = 8'hF0;
    run_prog(0, 1'b0);
    clear_prog(); prog[0] = 8'h80; prog[1] = 8'hFF; prog[8'hFF] = 8'hF0;
    run_prog(1, 1'b0);
    clear_prog(); prog[0] = 8'h20; prog[1] = 8'h80; prog[2] = 8'hF0;
    run_prog(8, 1'b1);

    for (int r = 0; r < 24; r++) begin
      gen_random();
      spur_en = (r >= 4);
      run_prog((r < 6) ? 0 : -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
